// File: rtl/incrementer.sv
// incrementer: registered up-counter advancing by a programmable step, with wrap or saturate at MAX_COUNT.
// Latency: count/wrap/sat_hit update 1 cycle after the sampled inputs; tc is a combinational decode of count.
// Backpressure: none; the inputs are sampled every rising edge. Priority is clr > load > en > hold.
//
// Ports:
//   clk, rst_n          : rising-edge clock and asynchronous active-low reset
//   clr, load, load_val : synchronous clear and synchronous parallel load (load value clamped to MAX_COUNT)
//   en, step, sat_mode  : increment enable, step size (clamped to MAX_COUNT), 1 = saturate / 0 = wrap
//   count, tc           : registered count, and terminal-count decode (count == MAX_COUNT)
//   wrap, sat_hit       : one-cycle registered pulses, set when the last update wrapped or clamped

module incrementer #(
  parameter int unsigned WIDTH     = 7,
  parameter int unsigned MAX_COUNT = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] step,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             sat_hit
);

  // MAX_COUNT at the count width, and one bit wider for the overflow-free sum.
  localparam logic [WIDTH-1:0] LP_MAX     = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH:0]   LP_MAX_EXT = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH:0]   LP_MODULUS = (WIDTH+1)'(MAX_COUNT + 1);

  if (MAX_COUNT < 1 || MAX_COUNT > 2**WIDTH - 1) begin : g_bad_max
    $error("incrementer: MAX_COUNT must lie in 1 .. 2**WIDTH-1");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_sat_hit;

  logic [WIDTH-1:0] w_load_eff;
  logic [WIDTH-1:0] w_step_eff;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;
  logic             w_sat_nxt;

  // Clamp the load value and the step to MAX_COUNT. With count <= MAX_COUNT and
  // step <= MAX_COUNT, the sum is at most 2*MAX_COUNT, so WIDTH+1 bits always hold it.
  assign w_load_eff = ({1'b0, load_val} > LP_MAX_EXT) ? LP_MAX : load_val;
  assign w_step_eff = ({1'b0, step}     > LP_MAX_EXT) ? LP_MAX : step;
  assign w_sum      = {1'b0, r_count} + {1'b0, w_step_eff};

  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    w_sat_nxt   = 1'b0;
    if (clr) begin
      w_count_nxt = '0;
    end else if (load) begin
      w_count_nxt = w_load_eff;
    end else if (en) begin
      if (w_sum <= LP_MAX_EXT) begin
        // A zero step also lands here: the count holds and no flag fires.
        w_count_nxt = w_sum[WIDTH-1:0];
      end else if (sat_mode) begin
        w_count_nxt = LP_MAX;
        w_sat_nxt   = 1'b1;
      end else begin
        // The difference is below MAX_COUNT+1, so it fits in WIDTH bits.
        w_count_nxt = WIDTH'(w_sum - LP_MODULUS);
        w_wrap_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_wrap    <= 1'b0;
      r_sat_hit <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_wrap    <= w_wrap_nxt;
      r_sat_hit <= w_sat_nxt;
    end
  end

  assign count   = r_count;
  assign tc      = (r_count == LP_MAX);
  assign wrap    = r_wrap;
  assign sat_hit = r_sat_hit;

endmodule

// File: tb/tb_incrementer.sv
// tb_incrementer: directed bench for incrementer (default 7-bit build and a MAX_COUNT=99 build).
// Latency: each vector is applied between edges and checked 1 time unit after the next rising edge.
// Backpressure: not applicable; the bench drives every cycle.

module tb_incrementer;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       load;
  logic [6:0] load_val;
  logic       en;
  logic [6:0] step;
  logic       sat_mode;

  logic [6:0] count;
  logic       tc;
  logic       wrap;
  logic       sat_hit;
  logic [6:0] count99;
  logic       tc99;
  logic       wrap99;
  logic       sat_hit99;

  int n_chk;
  int n_fail;

  incrementer #(.WIDTH(7)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .step(step), .sat_mode(sat_mode),
    .count(count), .tc(tc), .wrap(wrap), .sat_hit(sat_hit)
  );

  incrementer #(.WIDTH(7), .MAX_COUNT(99)) dut99 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .step(step), .sat_mode(sat_mode),
    .count(count99), .tc(tc99), .wrap(wrap99), .sat_hit(sat_hit99)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic l, input int lv, input logic e,
                       input int s, input logic sm);
    clr      = c;
    load     = l;
    load_val = 7'(lv);
    en       = e;
    step     = 7'(s);
    sat_mode = sm;
  endtask

  typedef struct {
    string name;
    int    clr, load, load_val, en, step, sat;
    int    e_count, e_tc, e_wrap, e_sat;
  } vec_t;

  vec_t vecs[18];

  initial begin
    n_chk  = 0;
    n_fail = 0;

    //            name           clr ld  lval en step sat  cnt tc wr sh
    vecs[0]  = '{"clear",         1, 0,   0, 0,   0, 0,    0, 0, 0, 0};
    vecs[1]  = '{"load125",       0, 1, 125, 0,   0, 0,  125, 0, 0, 0};
    vecs[2]  = '{"wrap_step5",    0, 0,   0, 1,   5, 0,    2, 0, 1, 0};
    vecs[3]  = '{"after_wrap",    0, 0,   0, 1,   5, 0,    7, 0, 0, 0};
    vecs[4]  = '{"load120",       0, 1, 120, 0,   0, 1,  120, 0, 0, 0};
    vecs[5]  = '{"sat_step10",    0, 0,   0, 1,  10, 1,  127, 1, 0, 1};
    vecs[6]  = '{"sat_again",     0, 0,   0, 1,  10, 1,  127, 1, 0, 1};
    vecs[7]  = '{"sat_en_off",    0, 0,   0, 0,  10, 1,  127, 1, 0, 0};
    vecs[8]  = '{"load30",        0, 1,  30, 0,   0, 0,   30, 0, 0, 0};
    vecs[9]  = '{"prio_clr",      1, 1,  50, 1,   1, 0,    0, 0, 0, 0};
    vecs[10] = '{"prio_load",     0, 1,  50, 1,   1, 0,   50, 0, 0, 0};
    vecs[11] = '{"step_zero",     0, 0,   0, 1,   0, 0,   50, 0, 0, 0};
    vecs[12] = '{"load127",       0, 1, 127, 0,   0, 0,  127, 1, 0, 0};
    vecs[13] = '{"wrap_from_max", 0, 0,   0, 1,   1, 0,    0, 0, 1, 0};
    vecs[14] = '{"load10",        0, 1,  10, 0,   0, 0,   10, 0, 0, 0};
    vecs[15] = '{"wrap_step127",  0, 0,   0, 1, 127, 0,    9, 0, 1, 0};
    vecs[16] = '{"sat_step127",   0, 0,   0, 1, 127, 1,  127, 1, 0, 1};
    vecs[17] = '{"hold_clears",   0, 0,   0, 0,   0, 0,  127, 1, 0, 0};

    // Reset state.
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("reset_count",   32'(count),   0);
    chk("reset_tc",      32'(tc),      0);
    chk("reset_wrap",    32'(wrap),    0);
    chk("reset_sat_hit", 32'(sat_hit), 0);
    chk("reset_count99", 32'(count99), 0);
    chk("reset_tc99",    32'(tc99),    0);

    // Full sweep: 128 enabled edges, step 1, wrap mode.
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 1, 1, 0);
    for (int i = 1; i <= 128; i++) begin
      tick();
      chk("sweep_count", 32'(count), 32'(i % 128));
      chk("sweep_tc",    32'(tc),    32'((i % 128) == 127));
      chk("sweep_wrap",  32'(wrap),  32'(i == 128));
    end
    drive(0, 0, 0, 0, 1, 0);
    tick();
    chk("sweep_wrap_one_cycle", 32'(wrap),  0);
    chk("sweep_hold_count",     32'(count), 0);

    // Table-driven single-cycle vectors on the default build.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].clr[0], vecs[i].load[0], vecs[i].load_val, vecs[i].en[0],
            vecs[i].step, vecs[i].sat[0]);
      tick();
      chk({vecs[i].name, "_count"},   32'(count),   32'(vecs[i].e_count));
      chk({vecs[i].name, "_tc"},      32'(tc),      32'(vecs[i].e_tc));
      chk({vecs[i].name, "_wrap"},    32'(wrap),    32'(vecs[i].e_wrap));
      chk({vecs[i].name, "_sat_hit"}, 32'(sat_hit), 32'(vecs[i].e_sat));
    end

    // MAX_COUNT=99 build: load clamp, step clamp with wrap, saturation.
    drive(0, 1, 120, 0, 0, 0);
    tick();
    chk("m99_load_clamp", 32'(count99), 99);
    chk("m99_load_tc",    32'(tc99),    1);
    drive(0, 1, 10, 0, 0, 0);
    tick();
    chk("m99_load10", 32'(count99), 10);
    drive(0, 0, 0, 1, 127, 0);
    tick();
    chk("m99_wrap_count", 32'(count99), 9);
    chk("m99_wrap_flag",  32'(wrap99),  1);
    chk("m99_wrap_nosat", 32'(sat_hit99), 0);
    drive(0, 0, 0, 1, 127, 1);
    tick();
    chk("m99_sat_count", 32'(count99),   99);
    chk("m99_sat_flag",  32'(sat_hit99), 1);
    chk("m99_sat_nowrap", 32'(wrap99),   0);

    // Asynchronous reset while a wrap pulse is pending.
    drive(0, 1, 127, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 1, 0);
    tick();
    chk("pre_reset_wrap", 32'(wrap), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_wrap",  32'(wrap),  0);
    chk("async_rst_count", 32'(count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset at count 64, then first enabled edge gives 1.
    drive(0, 1, 63, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 1, 0);
    tick();
    chk("pre_reset_count64", 32'(count), 64);
    #2 rst_n = 1'b0;
    #1;
    chk("async64_count", 32'(count),   0);
    chk("async64_tc",    32'(tc),      0);
    chk("async64_wrap",  32'(wrap),    0);
    chk("async64_sat",   32'(sat_hit), 0);
    tick();
    chk("in_reset_edge_ignored", 32'(count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_reset_first_edge", 32'(count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/incrementer.md
# incrementer

Synchronous, parameterizable up-counter that advances a registered count by a programmable step each enabled clock cycle. It supports wrap-around or saturation at a configurable maximum, synchronous clear, and parallel load. It drives terminal-count and wrap/saturate event flags. It serves as the shared sequence/index generator; the default configuration is a 7-bit counter sweeping 0..127.

## Interface
- WIDTH, 7, count register width in bits.
- MAX_COUNT, 2**WIDTH-1 (127), highest legal count; must satisfy 1 <= MAX_COUNT <= 2**WIDTH-1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low; the block has one clock, and this reset is asynchronous and active-low.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value loaded when load=1.
- en  input  1  increment enable.
- step  input  WIDTH  increment amount.
- sat_mode  input  1  1 = saturate at MAX_COUNT, 0 = wrap modulo MAX_COUNT+1.
- count  output  WIDTH  registered current count.
- tc  output  1  terminal count, combinational decode of count==MAX_COUNT.
- wrap  output  1  registered one-cycle pulse: the last update wrapped.
- sat_hit  output  1  registered one-cycle pulse: the last update clamped at MAX_COUNT.

## Operation
- Priority per clock edge: clr > load > en > hold.
- clr=1: count<=0; wrap<=0; sat_hit<=0.
- load=1 (clr=0): count<=min(load_val, MAX_COUNT); wrap<=0; sat_hit<=0.
- en=1 (clr=0, load=0):
  - Effective step s = min(step, MAX_COUNT).
  - Sum = count + s, computed in WIDTH+1 bits; the sum never overflows.
  - If sum <= MAX_COUNT: count<=sum; wrap<=0; sat_hit<=0.
  - If sum > MAX_COUNT and sat_mode=0: count<=sum-(MAX_COUNT+1); wrap<=1.
  - If sum > MAX_COUNT and sat_mode=1: count<=MAX_COUNT; sat_hit<=1.
  - If step=0: count holds; wrap=0; sat_hit=0.
- en=0 and no clr/load: count holds; wrap<=0; sat_hit<=0.
- wrap and sat_hit are mutually exclusive. Neither asserts on clr, load, or hold cycles.
- tc is high whenever count==MAX_COUNT, regardless of en.
- In saturate mode at MAX_COUNT with en=1 and step>0: sat_hit reasserts every cycle, and count stays at MAX_COUNT.

## Timing
- Asynchronous reset: while rst_n=0, count=0, wrap=0, sat_hit=0, tc=0 (MAX_COUNT>=1).
- Reset deassertion is synchronized externally. The first possible update is the first rising edge with rst_n=1.
- Update latency is 1 cycle: count, wrap, and sat_hit reflect the inputs sampled at the previous rising edge.
- tc follows count combinationally, with no extra latency.
- Reset asserted mid-operation clears all state immediately, independent of clk. No pending event flag survives reset.
- Inputs change only between rising edges; there is no handshake.
- Full sweep with step=1, sat_mode=0, en held high: count takes the values 0,1,...,MAX_COUNT,0. The wrap pulse occurs in cycle MAX_COUNT+1 after the first enabled edge, coincident with count returning to 0.

## Test plan
- Reset then 128 enabled cycles, step=1, sat_mode=0:
  - count steps 0..127, one value per cycle.
  - tc=1 only while count=127.
  - On the 128th edge: count=0 and wrap=1 for exactly one cycle.
- Wrap with step: load 125, then step=5, en=1 -> count=2, wrap=1. Next edge -> count=7, wrap=0.
- Saturate: sat_mode=1, load 120, step=10, en=1 -> count=127, sat_hit=1. It stays 127 with sat_hit=1 while enabled. With en=0 -> sat_hit=0.
- Priority: clr=1, load=1 (load_val=50), en=1 at count=30 -> count=0. Then load=1, en=1 -> count=50, not 51.
- Clamping:
  - MAX_COUNT=99 build: load_val=120 -> count=99.
  - step=127 from count=10 in wrap mode -> count=10+99-100=9, wrap=1.
- Async reset mid-run: assert rst_n=0 between edges at count=64 -> count=0, tc=0, wrap=0 immediately. After release, first enabled edge -> count=1.
